// File: rtl/router_sync_n.sv
// Router synchroniser for NUM_CH output FIFOs: latches the header address,
// decodes FIFO write enables, muxes back the full flag and flushes stale FIFOs.
module router_sync_n #(
    parameter int NUM_CH  = 3,
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 30
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              detect_add,
    input  logic              write_enb_reg,
    input  logic [NUM_CH-1:0] full,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] read_enb,
    output logic [NUM_CH-1:0] write_enb,
    output logic              fifo_full,
    output logic [NUM_CH-1:0] vld_out,
    output logic [NUM_CH-1:0] soft_reset,
    output logic              addr_err
);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    // One extra bit so NUM_CH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] NUM_CH_EXT = (ADDR_W + 1)'(NUM_CH);

    logic [ADDR_W-1:0] r_addr;
    logic              r_addr_err;
    logic [CNT_W-1:0]  r_cnt [NUM_CH];
    logic [NUM_CH-1:0] r_soft_reset;
    logic              w_addr_ok;
    logic [NUM_CH-1:0] w_sel;

    assign w_addr_ok = ({1'b0, r_addr} < NUM_CH_EXT);

    // One-hot channel select from the latched address; empty when out of range.
    always_comb begin
        w_sel = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_addr_ok && (r_addr == ADDR_W'(i))) begin
                w_sel[i] = 1'b1;
            end else begin
                w_sel[i] = 1'b0;
            end
        end
    end

    assign write_enb  = write_enb_reg ? w_sel : {NUM_CH{1'b0}};
    assign fifo_full  = |(full & w_sel);
    assign vld_out    = ~empty;
    assign soft_reset = r_soft_reset;
    assign addr_err   = r_addr_err;

    // Header address latch and its range flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr     <= {ADDR_W{1'b0}};
            r_addr_err <= 1'b0;
        end else if (detect_add) begin
            r_addr     <= data_in;
            r_addr_err <= ({1'b0, data_in} >= NUM_CH_EXT);
        end
    end

    // Per-channel unread-valid timers; a read or empty FIFO always wins over terminal count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= {CNT_W{1'b0}};
            end
            r_soft_reset <= {NUM_CH{1'b0}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (read_enb[i] || empty[i]) begin
                    r_cnt[i]        <= {CNT_W{1'b0}};
                    r_soft_reset[i] <= 1'b0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_cnt[i]        <= {CNT_W{1'b0}};
                    r_soft_reset[i] <= 1'b1;
                end else begin
                    r_cnt[i]        <= r_cnt[i] + CNT_W'(1'b1);
                    r_soft_reset[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/router_sync_n.md
# router_sync_n

Parametrised successor to the three-port router synchroniser. It sits between the router FSM and `NUM_CH` output FIFOs. It latches the destination address on header detect, decodes one-hot FIFO write enables, and muxes the selected FIFO's full flag back to the FSM. It also drives per-channel valid-out flags and one-cycle soft-reset pulses that flush a FIFO whose packet has not been read within `TIMEOUT` cycles.

## Interface
- `NUM_CH`, default 3: number of output channels/FIFOs, 1..8.
- `ADDR_W`, default 2: address field width. Requires 2**ADDR_W >= NUM_CH.
- `TIMEOUT`, default 30: consecutive unread-valid cycles before a soft reset, 2..255.
- `clock` input, 1 bit: single clock. All state updates on rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `data_in` input, ADDR_W bits: destination address field of the header byte.
- `detect_add` input, 1 bit: header present, so latch `data_in`.
- `write_enb_reg` input, 1 bit: FSM requests a FIFO write this cycle.
- `full` input, NUM_CH bits: per-FIFO full flags.
- `empty` input, NUM_CH bits: per-FIFO empty flags.
- `read_enb` input, NUM_CH bits: per-FIFO read strobes from the downstream ports.
- `write_enb` output, NUM_CH bits: one-hot FIFO write enable, combinational.
- `fifo_full` output, 1 bit: full flag of the addressed FIFO, combinational.
- `vld_out` output, NUM_CH bits: `~empty`, combinational.
- `soft_reset` output, NUM_CH bits: registered one-cycle flush pulse per FIFO.
- `addr_err` output, 1 bit: registered. The latched address is out of range (>= NUM_CH).

## Operation
- **Address register `addr_q`** (ADDR_W bits):
  - Reset value 0.
  - Loads `data_in` on any edge with `detect_add`=1; otherwise holds.
  - `addr_ok` = (`addr_q` < NUM_CH).
- **addr_err:**
  - Reset value 0.
  - On an edge with `detect_add`=1, loads (`data_in` >= NUM_CH); otherwise holds.
- **write_enb:**
  - When `write_enb_reg`=1 and `addr_ok`: bit `addr_q` set, all other bits 0.
  - Otherwise all zeros.
  - Never more than one bit set.
- **fifo_full:** `full[addr_q]` when `addr_ok`, else 0.
- **vld_out[i]:** `~empty[i]`, with no registering.
- **Per-channel timeout counter `cnt[i]`** (width clog2(TIMEOUT)), evaluated each edge in this priority order:
  1. `reset`: `cnt`=0, `soft_reset[i]`=0.
  2. `read_enb[i]`=1 or `vld_out[i]`=0: `cnt`=0, `soft_reset[i]`=0.
  3. `cnt`==TIMEOUT-1: `cnt`=0, `soft_reset[i]`=1.
  4. Otherwise: `cnt`=`cnt`+1, `soft_reset[i]`=0.
- **Counter behaviour:**
  - The counter never wraps past TIMEOUT-1.
  - A read strobe in the same cycle as terminal count takes priority: no pulse, counter cleared.
  - If the FIFO is still non-empty after the flush, counting restarts from 0. The next pulse then comes TIMEOUT edges later.
- **Channel independence:** channels are fully independent. Any combination of simultaneous pulses is legal.
- **Reset mid-operation:** all registers return to reset values asynchronously.
  - `write_enb` then decodes to channel 0 if `write_enb_reg`=1.
  - `fifo_full` tracks `full[0]`.

## Timing
- **Address latch:** `detect_add` sampled at edge k. `addr_q`/`addr_err` update at edge k, and `write_enb`/`fifo_full` reflect the new address in the cycle following edge k. Zero-cycle combinational path from `write_enb_reg` and `full` to the outputs.
- **Timeout pulse:** with `vld_out[i]`=1 and `read_enb[i]`=0 sampled at TIMEOUT consecutive edges, `soft_reset[i]` is high for exactly the one cycle after the TIMEOUT-th edge.
- **Reset release:** all registered outputs are 0 from reset assertion until the first edge after release.

## Test plan
Defaults: NUM_CH=3, ADDR_W=2, TIMEOUT=30.
1. **Address decode:** `detect_add` with `data_in`=1, then `write_enb_reg`=1 and `full`=3'b010 → `write_enb`=3'b010, `fifo_full`=1, `addr_err`=0.
2. **Invalid address:** `detect_add` with `data_in`=3, `write_enb_reg`=1 → `write_enb`=3'b000, `fifo_full`=0, `addr_err`=1. A following `detect_add` with `data_in`=2 → `addr_err`=0, `write_enb`=3'b100.
3. **Timeout:** `empty[0]`=0, `read_enb[0]`=0 held → `soft_reset[0]` high exactly one cycle after edge 30. It is high again one cycle after edge 60 if `empty[0]` stays 0.
4. **Read rescue:** `read_enb[1]` pulsed at edge 29 (`cnt`=28 to 29 blocked) or at edge 30 (terminal) → no `soft_reset[1]`. Counter restarts, so a pulse arrives 30 edges after `read_enb` drops.
5. **Simultaneous and empty:** channels 0 and 2 stalled from the same edge → both `soft_reset` bits pulse in the same cycle. Channel 1 with `empty`=1 never pulses.
6. **Async reset mid-count:** `reset` asserted between edges at `cnt`=20 → `soft_reset`=0, `addr_err`=0, `addr_q`=0 immediately. After release, a full 30 stalled edges are needed before the next pulse.
